// File: rtl/modport_fifo.sv
// rtl/modport_fifo.sv - synchronous FIFO with registered read data and count-decoded status flags
// Optional overflow/underflow pulses enabled by defining MODPORT_FIFO_ERR_EN.
module modport_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_wren,
   input  logic              i_rden,
   input  logic [DATA_W-1:0] i_wrdata,
   output logic [DATA_W-1:0] o_rddata,
   output logic              o_full,
   output logic              o_alm_full,
   output logic              o_empty,
   output logic              o_alm_empty
`ifdef MODPORT_FIFO_ERR_EN
   ,
   output logic              o_ovf,
   output logic              o_udf
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LVL);
   localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LVL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [CNT_W-1:0]  count;
   logic              wr_ok;
   logic              rd_ok;

   // Acceptance uses the registered flags, so a full FIFO drops writes even when a read frees a slot
   assign wr_ok = i_wren & ~o_full;
   assign rd_ok = i_rden & ~o_empty;

   assign o_full      = (count == FULL_C);
   assign o_empty     = (count == '0);
   assign o_alm_full  = (count >= AF_C);
   assign o_alm_empty = (count <= AE_C);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wptr] <= i_wrdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         o_rddata <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_ok) begin
            rptr     <= rptr + 1'b1;
            o_rddata <= mem[rptr];
         end
         if (wr_ok && !rd_ok) begin
            count <= count + 1'b1;
         end else if (rd_ok && !wr_ok) begin
            count <= count - 1'b1;
         end
      end
   end

`ifdef MODPORT_FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_ovf <= 1'b0;
         o_udf <= 1'b0;
      end else begin
         o_ovf <= i_wren & o_full;
         o_udf <= i_rden & o_empty;
      end
   end
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// tb/tb_modport_fifo.sv - scoreboard bench for modport_fifo (DATA_W=8, DEPTH=16, AF_LVL=14, AE_LVL=2)
module tb_modport_fifo;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       i_wren = 1'b0;
   logic       i_rden = 1'b0;
   logic [7:0] i_wrdata = '0;
   logic [7:0] o_rddata;
   logic       o_full;
   logic       o_alm_full;
   logic       o_empty;
   logic       o_alm_empty;
`ifdef MODPORT_FIFO_ERR_EN
   logic       o_ovf;
   logic       o_udf;
`endif

   modport_fifo #(
      .DATA_W (8),
      .DEPTH  (16),
      .AF_LVL (14),
      .AE_LVL (2)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_wren      (i_wren),
      .i_rden      (i_rden),
      .i_wrdata    (i_wrdata),
      .o_rddata    (o_rddata),
      .o_full      (o_full),
      .o_alm_full  (o_alm_full),
      .o_empty     (o_empty),
      .o_alm_empty (o_alm_empty)
`ifdef MODPORT_FIFO_ERR_EN
      ,
      .o_ovf       (o_ovf),
      .o_udf       (o_udf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] flg;
      logic [1:0] err;
   } exp_t;

   exp_t       exp_q [$];
   logic [7:0] mq [$];
   logic [7:0] m_rdata = '0;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   // Monitor: the DUT presents fresh outputs every cycle, checked away from the active edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         logic [11:0] act;
         e   = exp_q.pop_front();
         act = {o_rddata, o_full, o_alm_full, o_empty, o_alm_empty};
         cyc++;
         checks++;
         if (act !== {e.d, e.flg}) begin
            errors++;
            $display("FAIL data_flags cyc=%0d actual rddata=%h f/af/e/ae=%b required rddata=%h f/af/e/ae=%b",
                     cyc, act[11:4], act[3:0], e.d, e.flg);
         end
`ifdef MODPORT_FIFO_ERR_EN
         checks++;
         if ({o_ovf, o_udf} !== e.err) begin
            errors++;
            $display("FAIL ovf_udf cyc=%0d actual=%b required=%b", cyc, {o_ovf, o_udf}, e.err);
         end
`endif
      end
   end

   task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
      exp_t e;
      int   cnt;
      logic wa;
      logic ra;
      logic ovf;
      logic udf;
      @(negedge clk);
      rstn = r; i_wren = w; i_rden = rd; i_wrdata = d;
      @(posedge clk);
      cnt = mq.size();
      ovf = 1'b0;
      udf = 1'b0;
      if (!r) begin
         mq.delete();
         m_rdata = '0;
      end else begin
         wa  = w && (cnt < 16);
         ra  = rd && (cnt > 0);
         ovf = w && (cnt == 16);
         udf = rd && (cnt == 0);
         if (ra) m_rdata = mq.pop_front();
         if (wa) mq.push_back(d);
      end
      cnt   = mq.size();
      e.d   = m_rdata;
      e.flg = {cnt == 16, cnt >= 14, cnt == 0, cnt <= 2};
      e.err = {ovf, udf};
      exp_q.push_back(e);
   endtask

   initial begin
      step(0, 0, 0, 8'h00);
      step(0, 1, 1, 8'h55);
      step(1, 0, 0, 8'h00);
      step(1, 0, 0, 8'h00);
      // Fill 0x01..0x10, then a dropped 0xFF
      for (int i = 1; i <= 16; i++) step(1, 1, 0, 8'(i));
      step(1, 1, 0, 8'hFF);
      // Drain all 16, then an ignored 17th read
      for (int i = 0; i < 17; i++) step(1, 0, 1, 8'h00);
      // Hold count at 5 through pointer wrap
      for (int i = 0; i < 5; i++) step(1, 1, 0, 8'(8'h20 + i));
      for (int i = 0; i < 20; i++) step(1, 1, 1, 8'(8'h30 + i));
      for (int i = 0; i < 5; i++) step(1, 0, 1, 8'h00);
      // Empty + both: only the write lands
      step(1, 1, 1, 8'hA5);
      for (int i = 0; i < 15; i++) step(1, 1, 0, 8'(8'h60 + i));
      // Full + both: only the read lands, 0xEE lost
      step(1, 1, 1, 8'hEE);
      for (int i = 0; i < 16; i++) step(1, 0, 1, 8'h00);
      // Reset mid-operation with a write pending
      for (int i = 0; i < 6; i++) step(1, 1, 0, 8'(8'hC0 + i));
      step(0, 1, 0, 8'hDD);
      step(1, 0, 1, 8'h00);
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      checks++;
      if (m_rdata !== 8'h00 || o_rddata !== 8'h00 || o_empty !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_state actual rddata=%h empty=%b required rddata=00 empty=1",
                  o_rddata, o_empty);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
